// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluation, copies up to eight in-range sprites from primary to secondary OAM.
// Build option: define SPRITE_OVF_BUG_EN to reproduce the 2C02 diagonal overflow-scan bug.
module sprite_eval (
   input  logic       clk,
   input  logic       rst,
   input  logic       eval_start,
   input  logic [7:0] scanline,
   input  logic       sprite_16,
   output logic [7:0] oam_addr,
   input  logic [7:0] oam_data,
   output logic       sec_wr_en,
   output logic [4:0] sec_addr,
   output logic [7:0] sec_wr_data,
   output logic       eval_busy,
   output logic       eval_done,
   output logic [3:0] sprite_count,
   output logic       sprite_overflow,
   output logic       sprite0_hit_line
);

   // state   | meaning
   // IDLE    | waiting for eval_start
   // CLEAR   | fill secondary OAM with 0xFF, one byte per cycle
   // RD_Y    | oam_addr = Y byte of sprite n
   // CHK_Y   | range-check Y, on hit write Y to slot
   // RD_B    | oam_addr = byte m of sprite n
   // WR_B    | copy byte m into slot
   // OVF_RD  | overflow scan read (slots full)
   // OVF_CHK | overflow scan compare
   // DONE    | one-cycle completion pulse
   typedef enum logic [3:0] {
      IDLE, CLEAR, RD_Y, CHK_Y, RD_B, WR_B, OVF_RD, OVF_CHK, DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] line_q, line_d;
   logic       tall_q, tall_d;
   logic [6:0] n_q, n_d;
   logic [1:0] m_q, m_d;
   logic [3:0] slot_q, slot_d;
   logic [4:0] clr_q, clr_d;
`ifdef SPRITE_OVF_BUG_EN
   logic [1:0] ovf_m_q, ovf_m_d;
`endif

   logic [7:0] oam_addr_q, oam_addr_d;
   logic       sec_wr_en_q, sec_wr_en_d;
   logic [4:0] sec_addr_q, sec_addr_d;
   logic [7:0] sec_wr_data_q, sec_wr_data_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       s0_q, s0_d;

   logic [8:0] diff;
   logic       in_range;

   assign diff     = {1'b0, line_q} - {1'b0, oam_data};
   assign in_range = !diff[8] && (diff[7:0] < (tall_q ? 8'd16 : 8'd8));

   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      tall_d        = tall_q;
      n_d           = n_q;
      m_d           = m_q;
      slot_d        = slot_q;
      clr_d         = clr_q;
`ifdef SPRITE_OVF_BUG_EN
      ovf_m_d       = ovf_m_q;
`endif
      oam_addr_d    = oam_addr_q;
      sec_wr_en_d   = 1'b0;
      sec_addr_d    = sec_addr_q;
      sec_wr_data_d = sec_wr_data_q;
      count_d       = count_q;
      ovf_d         = ovf_q;
      s0_d          = s0_q;

      // Writes decided in CHK_Y / WR_B depend on oam_data, so they appear on the
      // secondary OAM port the following cycle.
      case (state_q)
         IDLE: ;
         CLEAR: begin
            if (clr_q == 5'd31) state_d = RD_Y;
            else                clr_d   = clr_q + 5'd1;
         end
         RD_Y: state_d = CHK_Y;
         CHK_Y: begin
            if (in_range) begin
               sec_wr_en_d   = 1'b1;
               sec_addr_d    = {slot_q[2:0], 2'b00};
               sec_wr_data_d = oam_data;
               m_d           = 2'd1;
               state_d       = RD_B;
               if (n_q == 7'd0) s0_d = 1'b1;
            end else begin
               n_d = n_q + 7'd1;
               if (n_d[6])         state_d = DONE;
               else if (slot_d[3]) state_d = OVF_RD;
               else                state_d = RD_Y;
            end
         end
         RD_B: state_d = WR_B;
         WR_B: begin
            sec_wr_en_d   = 1'b1;
            sec_addr_d    = {slot_q[2:0], m_q};
            sec_wr_data_d = oam_data;
            if (m_q != 2'd3) begin
               m_d     = m_q + 2'd1;
               state_d = RD_B;
            end else begin
               slot_d  = slot_q + 4'd1;
               count_d = slot_q + 4'd1;
               n_d     = n_q + 7'd1;
               if (n_d[6])         state_d = DONE;
               else if (slot_d[3]) state_d = OVF_RD;
               else                state_d = RD_Y;
            end
         end
         OVF_RD: state_d = OVF_CHK;
         OVF_CHK: begin
            if (in_range) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               n_d = n_q + 7'd1;
`ifdef SPRITE_OVF_BUG_EN
               ovf_m_d = ovf_m_q + 2'd1;
`endif
               state_d = n_d[6] ? DONE : OVF_RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (eval_start) begin
         line_d  = scanline;
         tall_d  = sprite_16;
         count_d = 4'd0;
         ovf_d   = 1'b0;
         s0_d    = 1'b0;
         n_d     = 7'd0;
         m_d     = 2'd0;
         slot_d  = 4'd0;
         clr_d   = 5'd0;
`ifdef SPRITE_OVF_BUG_EN
         ovf_m_d = 2'd0;
`endif
         state_d = CLEAR;
      end

      if (state_d == CLEAR) begin
         sec_wr_en_d   = 1'b1;
         sec_addr_d    = clr_d;
         sec_wr_data_d = 8'hFF;
      end

      case (state_d)
         RD_Y:    oam_addr_d = {n_d[5:0], 2'b00};
         RD_B:    oam_addr_d = {n_d[5:0], m_d};
`ifdef SPRITE_OVF_BUG_EN
         OVF_RD:  oam_addr_d = {n_d[5:0], ovf_m_d};
`else
         OVF_RD:  oam_addr_d = {n_d[5:0], 2'b00};
`endif
         default: oam_addr_d = oam_addr_q;
      endcase

      busy_d = (state_d != IDLE) && (state_d != DONE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         line_q        <= 8'd0;
         tall_q        <= 1'b0;
         n_q           <= 7'd0;
         m_q           <= 2'd0;
         slot_q        <= 4'd0;
         clr_q         <= 5'd0;
`ifdef SPRITE_OVF_BUG_EN
         ovf_m_q       <= 2'd0;
`endif
         oam_addr_q    <= 8'd0;
         sec_wr_en_q   <= 1'b0;
         sec_addr_q    <= 5'd0;
         sec_wr_data_q <= 8'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         count_q       <= 4'd0;
         ovf_q         <= 1'b0;
         s0_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         tall_q        <= tall_d;
         n_q           <= n_d;
         m_q           <= m_d;
         slot_q        <= slot_d;
         clr_q         <= clr_d;
`ifdef SPRITE_OVF_BUG_EN
         ovf_m_q       <= ovf_m_d;
`endif
         oam_addr_q    <= oam_addr_d;
         sec_wr_en_q   <= sec_wr_en_d;
         sec_addr_q    <= sec_addr_d;
         sec_wr_data_q <= sec_wr_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         s0_q          <= s0_d;
      end
   end

   assign oam_addr         = oam_addr_q;
   assign sec_wr_en        = sec_wr_en_q;
   assign sec_addr         = sec_addr_q;
   assign sec_wr_data      = sec_wr_data_q;
   assign eval_busy        = busy_q;
   assign eval_done        = done_q;
   assign sprite_count     = count_q;
   assign sprite_overflow  = ovf_q;
   assign sprite0_hit_line = s0_q;

endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: directed scenarios against sprite_eval with OAM memory models.
// Overflow expectations follow SPRITE_OVF_BUG_EN when the bench is built with it.
module tb_sprite_eval;
   logic       clk = 1'b0;
   logic       rst;
   logic       eval_start;
   logic [7:0] scanline;
   logic       sprite_16;
   logic [7:0] oam_addr;
   logic [7:0] oam_data;
   logic       sec_wr_en;
   logic [4:0] sec_addr;
   logic [7:0] sec_wr_data;
   logic       eval_busy;
   logic       eval_done;
   logic [3:0] sprite_count;
   logic       sprite_overflow;
   logic       sprite0_hit_line;

   logic [7:0] oam_mem [256];
   logic [7:0] sec_mem [32];
   logic [7:0] exp_sec [32];
   int checks = 0;
   int errors = 0;

   sprite_eval dut (
      .clk(clk), .rst(rst), .eval_start(eval_start), .scanline(scanline),
      .sprite_16(sprite_16), .oam_addr(oam_addr), .oam_data(oam_data),
      .sec_wr_en(sec_wr_en), .sec_addr(sec_addr), .sec_wr_data(sec_wr_data),
      .eval_busy(eval_busy), .eval_done(eval_done), .sprite_count(sprite_count),
      .sprite_overflow(sprite_overflow), .sprite0_hit_line(sprite0_hit_line)
   );

   always #5 clk = ~clk;
   always @(posedge clk) oam_data <= oam_mem[oam_addr];
   always @(posedge clk) if (sec_wr_en) sec_mem[sec_addr] <= sec_wr_data;

   task automatic fill_oam(input logic [7:0] y);
      for (int i = 0; i < 256; i++) oam_mem[i] = ((i % 4) == 0) ? y : 8'h00;
      for (int i = 0; i < 32; i++) sec_mem[i] = 8'h00;
   endtask

   task automatic set_sprite(input int idx, input logic [7:0] y, input logic [7:0] t,
                             input logic [7:0] a, input logic [7:0] x);
      oam_mem[4*idx] = y; oam_mem[4*idx+1] = t; oam_mem[4*idx+2] = a; oam_mem[4*idx+3] = x;
   endtask

   task automatic start_eval(input logic [7:0] line, input logic tall);
      @(negedge clk);
      scanline = line; sprite_16 = tall; eval_start = 1'b1;
      @(negedge clk);
      eval_start = 1'b0;
   endtask

   // Cycle count includes the edge that samples eval_start; -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (cyc < 400) begin
         @(posedge clk); cyc++; #1;
         if (eval_done) return;
      end
      cyc = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; eval_start = 1'b0; scanline = 8'd0; sprite_16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({oam_addr, sec_wr_en, sec_addr, sec_wr_data, eval_busy, eval_done,
           sprite_count, sprite_overflow, sprite0_hit_line} !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs: got oam_addr=%h wr=%b addr=%h data=%h busy=%b done=%b cnt=%0d ovf=%b s0=%b expected all zero",
                  oam_addr, sec_wr_en, sec_addr, sec_wr_data, eval_busy, eval_done,
                  sprite_count, sprite_overflow, sprite0_hit_line);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      int cyc;
      fill_oam(8'hF0);
      set_sprite(0, 8'd15, 8'h11, 8'h22, 8'h33);
      set_sprite(10, 8'd20, 8'h44, 8'h55, 8'h66);
      start_eval(8'd20, 1'b0);
      checks++;
      if ({eval_busy, sec_wr_en, sec_addr, sec_wr_data} !== {1'b1, 1'b1, 5'd0, 8'hFF}) begin
         errors++;
         $display("FAIL basic_clear_first: got busy=%b wr=%b addr=%0d data=%h expected 1 1 0 ff",
                  eval_busy, sec_wr_en, sec_addr, sec_wr_data);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 32 + 62*2 + 2*8 + 1) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, 32 + 62*2 + 2*8 + 1);
      end
      @(posedge clk); #1;
      checks++;
      if ({eval_done, eval_busy} !== 2'b00) begin
         errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", eval_done, eval_busy);
      end
      checks++;
      if ({sprite_count, sprite_overflow, sprite0_hit_line} !== {4'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL basic_flags: got cnt=%0d ovf=%b s0=%b expected 2 0 1",
                  sprite_count, sprite_overflow, sprite0_hit_line);
      end
      for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
      exp_sec[0] = 8'd15; exp_sec[1] = 8'h11; exp_sec[2] = 8'h22; exp_sec[3] = 8'h33;
      exp_sec[4] = 8'd20; exp_sec[5] = 8'h44; exp_sec[6] = 8'h55; exp_sec[7] = 8'h66;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (sec_mem[i] !== exp_sec[i]) begin
            errors++; $display("FAIL basic_sec[%0d]: got %h expected %h", i, sec_mem[i], exp_sec[i]);
         end
      end
   endtask

   task automatic test_boundary;
      int cyc;
      logic [7:0] ys   [4] = '{8'd12, 8'd12, 8'd21, 8'd21};
      logic       tall [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [3:0] expc [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
      for (int k = 0; k < 4; k++) begin
         fill_oam(8'hF0);
         set_sprite(5, ys[k], 8'hA5, 8'h01, 8'h80);
         start_eval(8'd20, tall[k]);
         wait_done(cyc);
         checks++;
         if (cyc !== ((expc[k] == 4'd1) ? 32 + 63*2 + 8 + 1 : 161)) begin
            errors++; $display("FAIL boundary%0d_latency: got %0d", k, cyc);
         end
         @(posedge clk); #1;
         checks++;
         if ({sprite_count, sprite0_hit_line, sprite_overflow} !== {expc[k], 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL boundary%0d_flags: got cnt=%0d s0=%b ovf=%b expected %0d 0 0",
                     k, sprite_count, sprite0_hit_line, sprite_overflow, expc[k]);
         end
         checks++;
         if (sec_mem[0] !== ((expc[k] == 4'd1) ? ys[k] : 8'hFF)) begin
            errors++; $display("FAIL boundary%0d_sec0: got %h", k, sec_mem[0]);
         end
      end
   endtask

   task automatic test_overflow;
      int cyc;
      fill_oam(8'hF0);
      for (int i = 0; i < 10; i++) set_sprite(i, 8'd50, 8'(i + 1), 8'(8'h80 + i), 8'(i * 8));
      start_eval(8'd50, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== 32 + 8*8 + 2 + 1) begin
         errors++; $display("FAIL overflow_latency: got %0d expected %0d", cyc, 32 + 8*8 + 2 + 1);
      end
      @(posedge clk); #1;
      checks++;
      if ({sprite_count, sprite_overflow, sprite0_hit_line} !== {4'd8, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL overflow_flags: got cnt=%0d ovf=%b s0=%b expected 8 1 1",
                  sprite_count, sprite_overflow, sprite0_hit_line);
      end
      for (int i = 0; i < 8; i++) begin
         exp_sec[4*i] = 8'd50; exp_sec[4*i+1] = 8'(i + 1);
         exp_sec[4*i+2] = 8'(8'h80 + i); exp_sec[4*i+3] = 8'(i * 8);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (sec_mem[i] !== exp_sec[i]) begin
            errors++; $display("FAIL overflow_sec[%0d]: got %h expected %h", i, sec_mem[i], exp_sec[i]);
         end
      end
   endtask

   task automatic test_ovf_diagonal;
      int cyc;
      int exp_cyc;
      logic exp_ovf;
`ifdef SPRITE_OVF_BUG_EN
      exp_ovf = 1'b1; exp_cyc = 32 + 8*8 + 2*2 + 1;
`else
      exp_ovf = 1'b0; exp_cyc = 32 + 8*8 + 56*2 + 1;
`endif
      fill_oam(8'hF0);
      for (int i = 0; i < 8; i++) set_sprite(i, 8'd50, 8'h00, 8'h00, 8'h00);
      set_sprite(9, 8'hF0, 8'd50, 8'h00, 8'h00);
      start_eval(8'd50, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== exp_cyc) begin
         errors++; $display("FAIL diag_latency: got %0d expected %0d", cyc, exp_cyc);
      end
      @(posedge clk); #1;
      checks++;
      if ({sprite_count, sprite_overflow} !== {4'd8, exp_ovf}) begin
         errors++;
         $display("FAIL diag_flags: got cnt=%0d ovf=%b expected 8 %b", sprite_count, sprite_overflow, exp_ovf);
      end
   endtask

   task automatic test_restart;
      int cyc;
      fill_oam(8'hF0);
      set_sprite(0, 8'd15, 8'h11, 8'h22, 8'h33);
      set_sprite(10, 8'd20, 8'h44, 8'h55, 8'h66);
      start_eval(8'd20, 1'b0);
      repeat (39) @(negedge clk);
      checks++;
      if (sprite0_hit_line !== 1'b1) begin
         errors++; $display("FAIL restart_pre_s0: got %b expected 1", sprite0_hit_line);
      end
      start_eval(8'd20, 1'b0);
      checks++;
      if ({sprite_count, sprite0_hit_line, sec_wr_en, sec_addr} !== {4'd0, 1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL restart_cleared: got cnt=%0d s0=%b wr=%b addr=%0d expected 0 0 1 0",
                  sprite_count, sprite0_hit_line, sec_wr_en, sec_addr);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 32 + 62*2 + 2*8 + 1) begin
         errors++; $display("FAIL restart_latency: got %0d expected %0d", cyc, 32 + 62*2 + 2*8 + 1);
      end
      @(posedge clk); #1;
      checks++;
      if ({sprite_count, sprite_overflow, sprite0_hit_line} !== {4'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL restart_flags: got cnt=%0d ovf=%b s0=%b expected 2 0 1",
                  sprite_count, sprite_overflow, sprite0_hit_line);
      end
      for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
      exp_sec[0] = 8'd15; exp_sec[1] = 8'h11; exp_sec[2] = 8'h22; exp_sec[3] = 8'h33;
      exp_sec[4] = 8'd20; exp_sec[5] = 8'h44; exp_sec[6] = 8'h55; exp_sec[7] = 8'h66;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (sec_mem[i] !== exp_sec[i]) begin
            errors++; $display("FAIL restart_sec[%0d]: got %h expected %h", i, sec_mem[i], exp_sec[i]);
         end
      end
   endtask

   task automatic test_rst_mid;
      fill_oam(8'hF0);
      set_sprite(0, 8'd15, 8'h11, 8'h22, 8'h33);
      start_eval(8'd20, 1'b0);
      // Edges 1..35 after the start edge: state is now the first WR_B of sprite 0.
      repeat (35) @(posedge clk);
      #1;
      checks++;
      if ({eval_busy, oam_addr} !== {1'b1, 8'd1}) begin
         errors++; $display("FAIL rst_mid_pre: got busy=%b oam_addr=%0d expected 1 1", eval_busy, oam_addr);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({oam_addr, sec_wr_en, sec_addr, sec_wr_data, eval_busy, eval_done,
           sprite_count, sprite_overflow, sprite0_hit_line} !== 31'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got oam_addr=%h wr=%b addr=%h data=%h busy=%b done=%b cnt=%0d ovf=%b s0=%b expected all zero",
                  oam_addr, sec_wr_en, sec_addr, sec_wr_data, eval_busy, eval_done,
                  sprite_count, sprite_overflow, sprite0_hit_line);
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({eval_busy, sec_wr_en} !== 2'b00) begin
         errors++; $display("FAIL rst_mid_stays_idle: got busy=%b wr=%b expected 0 0", eval_busy, sec_wr_en);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_boundary;
      test_overflow;
      test_ovf_diagonal;
      test_restart;
      test_rst_mid;
      test_basic;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
